us_delay_timer: RTL and testbench

- Consumer of the system 1 µs strobe: counts one-clk-wide tick_1us pulses down from a loaded duration.
- Signals expiry with a one-cycle done pulse.
- Supports one-shot and periodic (auto-reload) operation, abort, and optional retrigger.
- Used by protocol/timing blocks needing programmable µs delays without a private prescaler.

---
 rtl/us_delay_timer_pkg.sv | 18 +
 rtl/us_delay_timer.sv | 115 +++++++++++
 tb/tb_us_delay_timer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/us_delay_timer_pkg.sv
// ----------------------------------------------------------------------------
// us_delay_timer_pkg
//   Shared definitions for the microsecond delay timer: the FSM state
//   encoding and the default counter width.
// ----------------------------------------------------------------------------
package us_delay_timer_pkg;

    // Default width of the duration / remaining counter (max 2^16-1 us).
    localparam int US_DLY_DEFAULT_W = 16;

    // Timer FSM. There is no separate DONE state: done is a pulse emitted on
    // the RUN->IDLE (one-shot) or RUN->RUN (reload) transition.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : us_delay_timer_pkg

// File: rtl/us_delay_timer.sv
// ----------------------------------------------------------------------------
// us_delay_timer
//   Counts pulses of an external 1 us strobe down from a loaded duration and
//   emits a one-clk done pulse on expiry. Supports one-shot and periodic
//   (auto-reload) operation, abort, and optional retrigger while running.
//
//   Parameters
//     W          width of duration / remaining counter
//     RETRIGGER  1: start while running reloads; 0: start ignored while running
//
//   Ports
//     clk        system clock
//     rst_n      asynchronous active-low reset
//     tick_1us   one-clk strobe, once per microsecond (shared strobe source)
//     start      one-clk request; samples dur_us and periodic when accepted
//     dur_us     duration in microseconds
//     periodic   1 = auto-reload on expiry
//     abort      stop the timer without generating done
//     busy       high while in RUN (directly reflects the FSM state)
//     done       registered one-clk pulse on each expiry
//     remaining  current count value (registered)
//
//   Request semantics: start and abort are single-cycle strobes with no
//   ready/acknowledge. A start is accepted in IDLE always and in RUN only
//   when RETRIGGER=1; a dropped start leaves every register untouched.
//   Priority per cycle: abort > accepted start > tick-driven count/expiry.
// ----------------------------------------------------------------------------
module us_delay_timer
    import us_delay_timer_pkg::*;
#(
    parameter int W         = US_DLY_DEFAULT_W,
    parameter bit RETRIGGER = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick_1us,
    input  logic         start,
    input  logic [W-1:0] dur_us,
    input  logic         periodic,
    input  logic         abort,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] remaining
);

    state_t         state_q,     state_d;
    logic [W-1:0]   remaining_q, remaining_d;
    logic [W-1:0]   reload_q,    reload_d;
    logic           per_q,       per_d;
    logic           done_q,      done_d;
    logic           start_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            reload_q    <= '0;
            per_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            reload_q    <= reload_d;
            per_q       <= per_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        reload_d    = reload_q;
        per_d       = per_q;
        done_d      = 1'b0;
        start_acc   = start && ((state_q == ST_IDLE) || RETRIGGER);

        if (abort) begin
            // In IDLE the counter is already zero, so this is a no-op there,
            // but it still swallows a simultaneous start.
            state_d     = ST_IDLE;
            remaining_d = '0;
        end else if (start_acc) begin
            reload_d = dur_us;
            per_d    = periodic;
            if (dur_us == '0) begin
                // Zero duration expires immediately; periodic is ignored.
                state_d     = ST_IDLE;
                remaining_d = '0;
                done_d      = 1'b1;
            end else begin
                // A tick in this cycle is deliberately not counted.
                state_d     = ST_RUN;
                remaining_d = dur_us;
            end
        end else if ((state_q == ST_RUN) && tick_1us) begin
            if (remaining_q == W'(1)) begin
                done_d = 1'b1;
                if (per_q) begin
                    remaining_d = reload_q;
                end else begin
                    state_d     = ST_IDLE;
                    remaining_d = '0;
                end
            end else if (remaining_q != '0) begin
                // Guarded so the counter can never wrap below zero.
                remaining_d = remaining_q - W'(1);
            end
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = done_q;
    assign remaining = remaining_q;

endmodule : us_delay_timer

// File: tb/tb_us_delay_timer.sv
// ----------------------------------------------------------------------------
// tb_us_delay_timer
//   Drives two timer instances (RETRIGGER=0 and RETRIGGER=1) from the same
//   inputs and checks them against a behavioural model, a vector table and
//   hand-written corner-case sequences.
// ----------------------------------------------------------------------------
module tb_us_delay_timer;

    localparam int W = 16;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic         tick_1us, start, periodic, abort;
    logic [W-1:0] dur_us;
    logic         busy0, done0, busy1, done1;
    logic [W-1:0] rem0, rem1;

    always #25 clk = ~clk;   // 20 MHz

    us_delay_timer #(.W(W), .RETRIGGER(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1us(tick_1us), .start(start),
        .dur_us(dur_us), .periodic(periodic), .abort(abort),
        .busy(busy0), .done(done0), .remaining(rem0)
    );

    us_delay_timer #(.W(W), .RETRIGGER(1'b1)) dut_rt (
        .clk(clk), .rst_n(rst_n), .tick_1us(tick_1us), .start(start),
        .dur_us(dur_us), .periodic(periodic), .abort(abort),
        .busy(busy1), .done(done1), .remaining(rem1)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt [2];
    logic [W-1:0] exp_q[$];

    // Behavioural reference: one timer per instance, plain integers.
    bit m_run   [2];
    int m_rem   [2];
    int m_load  [2];
    bit m_per   [2];
    bit m_done  [2];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_rem[k] = 0; m_load[k] = 0; m_per[k] = 0; m_done[k] = 0;
        end
    endtask

    // One clock of the timer described as events: abort wins, then an
    // accepted start loads a new run, otherwise a tick consumes one us.
    task automatic model_cycle(input int k, input bit retrig);
        m_done[k] = 0;
        if (abort) begin
            m_run[k] = 0;
            m_rem[k] = 0;
        end else if (start && (!m_run[k] || retrig)) begin
            m_load[k] = int'(dur_us);
            m_per[k]  = periodic;
            if (dur_us == 0) begin
                m_run[k] = 0; m_rem[k] = 0; m_done[k] = 1;
            end else begin
                m_run[k] = 1; m_rem[k] = int'(dur_us);
            end
        end else if (m_run[k] && tick_1us) begin
            if (m_rem[k] == 1) begin
                m_done[k] = 1;
                if (m_per[k]) m_rem[k] = m_load[k];
                else begin m_run[k] = 0; m_rem[k] = 0; end
            end else begin
                m_rem[k] = m_rem[k] - 1;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge; drives inputs, lets one rising edge pass,
    // advances the model, then compares on the next falling edge.
    task automatic step(input logic t, input logic s, input logic [W-1:0] d,
                        input logic p, input logic a);
        tick_1us = t; start = s; dur_us = d; periodic = p; abort = a;
        @(posedge clk);
        model_cycle(0, 1'b0);
        model_cycle(1, 1'b1);
        @(negedge clk);
        check("busy_r0", int'(busy0), int'(m_run[0]));
        check("done_r0", int'(done0), int'(m_done[0]));
        check("rem_r0",  int'(rem0),  m_rem[0]);
        check("busy_r1", int'(busy1), int'(m_run[1]));
        check("done_r1", int'(done1), int'(m_done[1]));
        check("rem_r1",  int'(rem1),  m_rem[1]);
        if (done0) done_cnt[0]++;
        if (done1) done_cnt[1]++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic tick_gap(input int gap);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        idle(gap - 1);
    endtask

    // Issues ticks until both instances have pulsed done (bounded by max).
    // Returns the 1-based tick index of each first done, 0 if none.
    task automatic ticks_until_done(input int max, output int n0, output int n1);
        n0 = 0; n1 = 0;
        for (int i = 1; i <= max; i++) begin
            step(1'b1, 1'b0, '0, 1'b0, 1'b0);
            if (done0 && n0 == 0) n0 = i;
            if (done1 && n1 == 0) n1 = i;
            idle(2);
            if (n0 != 0 && n1 != 0) break;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         t, s;
        logic [W-1:0] d;
        logic         p, a;
        logic         eb, ed;
        logic [W-1:0] er;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(logic t, logic s, logic [W-1:0] d, logic p,
                                logic a, logic eb, logic ed, logic [W-1:0] er);
        vec_t v;
        v.t = t; v.s = s; v.d = d; v.p = p; v.a = a; v.eb = eb; v.ed = ed; v.er = er;
        return v;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int n0, n1, c0, c1;
        logic prev_t;

        //           tick start dur      per abort busy done rem
        tbl[0]  = mk(0, 1, 16'd3,      0, 0,  1, 0, 16'd3);
        tbl[1]  = mk(1, 0, 16'd0,      0, 0,  1, 0, 16'd2);
        tbl[2]  = mk(0, 0, 16'd0,      0, 0,  1, 0, 16'd2);
        tbl[3]  = mk(1, 0, 16'd0,      0, 0,  1, 0, 16'd1);
        tbl[4]  = mk(1, 0, 16'd0,      0, 0,  0, 1, 16'd0);
        tbl[5]  = mk(0, 0, 16'd0,      0, 0,  0, 0, 16'd0);
        tbl[6]  = mk(0, 1, 16'd0,      1, 0,  0, 1, 16'd0);
        tbl[7]  = mk(0, 0, 16'd0,      0, 0,  0, 0, 16'd0);
        tbl[8]  = mk(1, 1, 16'hFFFF,   0, 0,  1, 0, 16'hFFFF);
        tbl[9]  = mk(1, 0, 16'd0,      0, 0,  1, 0, 16'hFFFE);
        tbl[10] = mk(1, 0, 16'd0,      0, 1,  0, 0, 16'd0);
        tbl[11] = mk(0, 0, 16'd0,      0, 1,  0, 0, 16'd0);
        tbl[12] = mk(0, 1, 16'd2,      1, 0,  1, 0, 16'd2);
        tbl[13] = mk(1, 0, 16'd0,      0, 0,  1, 0, 16'd1);
        tbl[14] = mk(1, 0, 16'd0,      0, 0,  1, 1, 16'd2);
        tbl[15] = mk(0, 0, 16'd0,      0, 0,  1, 0, 16'd2);
        tbl[16] = mk(1, 0, 16'd0,      0, 0,  1, 0, 16'd1);
        tbl[17] = mk(1, 0, 16'd0,      0, 1,  0, 0, 16'd0);
        tbl[18] = mk(0, 1, 16'd5,      0, 1,  0, 0, 16'd0);

        done_cnt[0] = 0; done_cnt[1] = 0;
        tick_1us = 0; start = 0; dur_us = '0; periodic = 0; abort = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy0), 0);
        check("reset_done", int'(done0), 0);
        check("reset_rem",  int'(rem0),  0);
        rst_n = 1'b1;
        idle(2);

        // Table vectors (no start ever lands in RUN, so both instances agree).
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].t, tbl[i].s, tbl[i].d, tbl[i].p, tbl[i].a);
            check($sformatf("tbl%0d_busy", i), int'(busy0), int'(tbl[i].eb));
            check($sformatf("tbl%0d_done", i), int'(done0), int'(tbl[i].ed));
            check($sformatf("tbl%0d_rem",  i), int'(rem0),  int'(tbl[i].er));
            check($sformatf("tbl%0d_rem_rt", i), int'(rem1), int'(tbl[i].er));
        end
        idle(3);

        // One-shot, ticks every 20 clk: remaining steps 5..0.
        exp_q = {16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
        step(1'b0, 1'b1, 16'd5, 1'b0, 1'b0);
        check("oneshot_rem_start", int'(rem0), int'(exp_q.pop_front()));
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, '0, 1'b0, 1'b0);
            check("oneshot_rem",  int'(rem0),  int'(exp_q.pop_front()));
            check("oneshot_done", int'(done0), (i == 4) ? 1 : 0);
            check("oneshot_busy", int'(busy0), (i < 4) ? 1 : 0);
            idle(19);
        end

        // Periodic dur=3: 4 expiries with reload, then abort on an expiry tick.
        c0 = done_cnt[0];
        step(1'b0, 1'b1, 16'd3, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) tick_gap(4);
        check("periodic_dones", done_cnt[0] - c0, 4);
        check("periodic_busy",  int'(busy0), 1);
        check("periodic_rem",   int'(rem0),  3);
        tick_gap(4);
        tick_gap(4);
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        check("abort_expiry_done", int'(done0), 0);
        check("abort_expiry_busy", int'(busy0), 0);
        check("periodic_dones_after_abort", done_cnt[0] - c0, 4);
        idle(3);

        // Retrigger: dur=8, 5 ticks, then start dur=6.
        step(1'b0, 1'b1, 16'd8, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick_gap(3);
        step(1'b0, 1'b1, 16'd6, 1'b0, 1'b0);
        check("retrig_rem_r0", int'(rem0), 3);
        check("retrig_rem_r1", int'(rem1), 6);
        ticks_until_done(10, n0, n1);
        check("retrig_ticks_r0", n0, 3);
        check("retrig_ticks_r1", n1, 6);
        idle(3);

        // Start coincident with a tick: that tick is not counted.
        step(1'b1, 1'b1, 16'd2, 1'b0, 1'b0);
        check("coinc_rem", int'(rem0), 2);
        idle(2);
        ticks_until_done(5, n0, n1);
        check("coinc_ticks", n0, 2);
        idle(3);

        // Reset mid-RUN: dur=10, 3 ticks, then asynchronous reset.
        step(1'b0, 1'b1, 16'd10, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick_gap(3);
        check("prereset_rem", int'(rem0), 7);
        #5 rst_n = 1'b0;
        #1;
        check("midreset_busy",  int'(busy0), 0);
        check("midreset_rem",   int'(rem0),  0);
        check("midreset_done",  int'(done0), 0);
        check("midreset_rem_rt", int'(rem1), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        c0 = done_cnt[0]; c1 = done_cnt[1];
        for (int i = 0; i < 12; i++) tick_gap(3);
        check("postreset_dones_r0", done_cnt[0] - c0, 0);
        check("postreset_dones_r1", done_cnt[1] - c1, 0);

        // Randomized traffic against the model; ticks kept >= 2 clk apart.
        prev_t = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            logic t, s, p, a;
            logic [W-1:0] d;
            t = !prev_t && ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 11) == 0);
            d = ($urandom_range(0, 15) == 0) ? W'($urandom_range(0, 65535))
                                             : W'($urandom_range(0, 6));
            p = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 49) == 0);
            step(t, s, d, p, a);
            prev_t = t;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_us_delay_timer
